fc2_bias_sink: RTL and testbench
================================

Name: fc2_bias_sink

Overview:
- Stream-to-memory capture block: the consuming end of the parameter-source valid/ready stream.
- Accepts parallel beats of BIAS_PARALLELISM_DIM_0 x BIAS_PRECISION_0-bit elements and writes each beat, packed, into an internal RAM of OUT_DEPTH words at sequential addresses.
- Exposes a registered read port with the same latency and ce semantics as the parameter ROMs, so captured tensors can be read back by a downstream engine or by the testbench.
- Sits at the output of a compute stage for parameter capture and hardware-in-loop checking.

Parameters:
BIAS_TENSOR_SIZE_DIM_0, 32, tensor elements along dim 0
BIAS_TENSOR_SIZE_DIM_1, 1, tensor elements along dim 1
BIAS_PRECISION_0, 16, element width in bits
BIAS_PRECISION_1, 3, fractional bits; informational only, no effect on logic
BIAS_PARALLELISM_DIM_0, 1, elements per beat along dim 0
BIAS_PARALLELISM_DIM_1, 1, elements per beat along dim 1; must be 1
OUT_DEPTH, TENSOR_SIZE_DIM_0*TENSOR_SIZE_DIM_1/(PAR_DIM_0*PAR_DIM_1), beats per tensor = RAM words
WRAP, 0, 0 = stop when full; 1 = wrap to address 0 and keep accepting

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
data_in  in  BIAS_PRECISION_0 x BIAS_PARALLELISM_DIM_0 (unpacked array)  beat elements
data_in_valid  in  1  beat valid
data_in_ready  out  1  sink can accept a beat
clear  in  1  single-cycle restart of capture
done  out  1  tensor fully captured (sticky until clear or rst)
count  out  $clog2(OUT_DEPTH+1)  beats written since last clear
rd_addr  in  $clog2(OUT_DEPTH+1)  readback address
rd_ce  in  1  readback pipeline enable
rd_data  out  BIAS_PRECISION_0*BIAS_PARALLELISM_DIM_0  packed readback word, element j at bits [P0*j +: P0]

Behaviour:
- Reset (rst high at a clock edge): state=FILL, count=0, done=0, both read pipeline registers=0, so rd_data=0. data_in_ready=0 while rst is high. RAM contents are not cleared and are undefined until written.
- States: FILL, FULL.
- data_in_ready = !rst && !clear && state==FILL. Combinational from registered state; no dependence on data_in_valid.
- Accept occurs when valid && ready at a clock edge. On accept, RAM[wr_ptr] <= packed data_in, with element j at bits [P0*j +: P0].
- wr_ptr is the internal write address, 0..OUT_DEPTH-1.
- WRAP=0:
  - Each accept increments count and wr_ptr.
  - The accept that makes count==OUT_DEPTH sets done=1 and moves state to FULL.
  - In FULL, ready=0; valid beats are held off by backpressure, not dropped.
- WRAP=1:
  - State stays FILL.
  - wr_ptr wraps from OUT_DEPTH-1 to 0.
  - count saturates at OUT_DEPTH.
  - done sets on the first wrap and stays set.
- clear (any state): next cycle state=FILL, count=0, wr_ptr=0, done=0. A beat presented with clear is not accepted because ready=0. RAM is untouched.
- rst has priority over clear. rst mid-tensor abandons the partial capture; the next accepted beat writes address 0.
- Read port:
  - Two-stage pipeline: stage0 <= RAM[rd_addr] if rd_ce; rd_data <= stage0 if rd_ce.
  - Latency is 2 enabled cycles.
  - rd_ce=0 freezes both stages.
  - rd_addr >= OUT_DEPTH returns undefined data; no error is flagged.
- Read/write collision (same address, same cycle): the read returns old contents (read-before-write). A word written at edge t is visible to a read sampled at edge t+1, and appears on rd_data after edge t+2.
- Read port is independent of capture state; it is usable during FILL and FULL.
- Throughput: one beat per cycle while in FILL.

Test Plan:
- Defaults, WRAP=0: drive 32 beats, data_in[0]=16'h1000+i, valid held high → ready=1 for 32 cycles then 0. done=1 and count=32 after beat 31. Beat 33 (16'hBEEF) stalls and is never written.
- Readback after fill: rd_ce=1, rd_addr=0..31 on successive cycles → rd_data = 16'h1000..16'h101F, each 2 cycles after its address.
- Random valid (50%) with PAR_DIM_0=4, P0=8, OUT_DEPTH=8: beat k elements {4k+3,4k+2,4k+1,4k} → RAM[k] = 32'h(4k+3)(4k+2)(4k+1)(4k). No beat lost or duplicated. count tracks accepts exactly.
- clear in FULL with valid=1 on the same cycle → no accept that cycle. Next cycle done=0, count=0, ready=1. The next beat 16'hAAAA lands at address 0 and address 1 keeps 16'h1001.
- rst asserted after 10 beats → ready=0 during rst, count=0 after. A new 32-beat stream fills addresses 0..31 and sets done.
- WRAP=1, OUT_DEPTH=4: 6 beats valued 1..6 → RAM = {5,6,3,4} at addresses 0..3, done=1 after beat 4, count=4, ready stays 1.
- Collision: write 16'h5555 to address 3 while reading address 3 (old value 16'h1003) → returned 16'h1003. Next read of address 3 returns 16'h5555.

Source files
------------

// File: rtl/fc2_bias_sink_if.sv
// ---------------------------------------------------------------------------
// fc2_bias_sink_if
//   Valid/ready beat stream carrying BIAS_PARALLELISM_DIM_0 elements of
//   BIAS_PRECISION_0 bits each.
//
//   data_in        beat elements (unpacked, element j = data_in[j])
//   data_in_valid  producer has a beat
//   data_in_ready  consumer will take the beat at the next clock edge
//
//   modport master : stream producer
//   modport slave  : stream consumer
// ---------------------------------------------------------------------------
interface fc2_bias_sink_if #(
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PARALLELISM_DIM_0 = 1
);

  logic [BIAS_PRECISION_0-1:0] data_in [BIAS_PARALLELISM_DIM_0];
  logic                        data_in_valid;
  logic                        data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );

endinterface : fc2_bias_sink_if

// File: rtl/fc2_bias_sink.sv
// ---------------------------------------------------------------------------
// fc2_bias_sink
//   Consuming end of a parameter stream. Each accepted beat is packed
//   (element j at bits [P0*j +: P0]) and written into an OUT_DEPTH-word RAM
//   at sequential addresses. A two-stage, ce-gated read port lets a
//   downstream engine read the captured tensor back.
//
//   Ports
//     clk      clock
//     rst      synchronous active-high reset
//     in_if    slave side of the beat stream (data_in / valid / ready)
//     clear    single-cycle capture restart (pointer, count, done)
//     done     tensor fully captured; sticky until clear or rst
//     count    beats written since last clear (saturates at OUT_DEPTH)
//     rd_addr  readback address
//     rd_ce    readback pipeline enable; 0 freezes both stages
//     rd_data  packed readback word, 2 enabled cycles after rd_addr
//
//   WRAP = 0 : stop at OUT_DEPTH beats and backpressure further input.
//   WRAP = 1 : wrap the write pointer and keep accepting.
// ---------------------------------------------------------------------------
module fc2_bias_sink #(
  parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
  parameter int BIAS_TENSOR_SIZE_DIM_1 = 1,
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PRECISION_1       = 3,
  parameter int BIAS_PARALLELISM_DIM_0 = 1,
  parameter int BIAS_PARALLELISM_DIM_1 = 1,
  parameter int OUT_DEPTH              = BIAS_TENSOR_SIZE_DIM_0 * BIAS_TENSOR_SIZE_DIM_1 /
                                         (BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1),
  parameter int WRAP                   = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  fc2_bias_sink_if.slave                                    in_if,
  input  logic                                              clear,
  output logic                                              done,
  output logic [$clog2(OUT_DEPTH+1)-1:0]                    count,
  input  logic [$clog2(OUT_DEPTH+1)-1:0]                    rd_addr,
  input  logic                                              rd_ce,
  output logic [BIAS_PRECISION_0*BIAS_PARALLELISM_DIM_0-1:0] rd_data
);

  localparam int P0  = BIAS_PRECISION_0;
  localparam int PAR = BIAS_PARALLELISM_DIM_0;
  localparam int DW  = P0 * PAR;
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int AW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(OUT_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(OUT_DEPTH);

  // Only one row of elements per beat is supported, and the fractional
  // bit count is a label that must still fit inside the element.
  if (BIAS_PARALLELISM_DIM_1 != 1 || BIAS_PRECISION_1 > BIAS_PRECISION_0) begin : g_cfg_check
    $error("fc2_bias_sink: unsupported parameter combination");
  end

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t         state_q;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           done_q;

  logic           ready;
  logic           accept;
  logic [DW-1:0]  wr_word;

  logic [DW-1:0]  mem [OUT_DEPTH];
  logic [AW-1:0]  rd_idx;
  logic           rd_in_range;
  logic [DW-1:0]  rd_stage0_q;
  logic [DW-1:0]  rd_data_q;

  // ready depends only on registered state plus rst/clear, never on valid,
  // so the producer sees no combinational loop through this block.
  assign ready               = !rst && !clear && (state_q == FILL);
  assign in_if.data_in_ready = ready;
  assign accept              = ready && in_if.data_in_valid;

  // Pointer wraps at the last word; count saturates at OUT_DEPTH so WRAP=1
  // streams of any length report a full tensor rather than overflowing.
  always_comb begin
    wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
    count_d  = (count_q == DEPTH_CNT) ? count_q : count_q + CW'(1);
  end

  always_comb begin
    // NOTE: a default before the loop keeps every bit assigned on every
    // path, so no latch is inferred.
    wr_word = '0;
    for (int j = 0; j < PAR; j++) begin
      wr_word[P0*j +: P0] = in_if.data_in[j];
    end
  end

  // Capture control. rst and clear restart identically; rst wins simply by
  // also forcing ready low, so no beat can slip in under either.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst || clear) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else if (accept) begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (WRAP != 0) begin
        if (wr_ptr_q == LAST_ADDR) begin
          done_q <= 1'b1;
        end
      end else if (count_d == DEPTH_CNT) begin
        done_q  <= 1'b1;
        state_q <= FULL;
      end
    end
  end

  // NOTE: the capture RAM has no reset; it holds whatever was last written,
  // which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  // Out-of-range reads return zero instead of aliasing into the array.
  assign rd_idx      = rd_addr[AW-1:0];
  assign rd_in_range = (rd_addr < DEPTH_CNT);

  // Both read stages advance together under rd_ce. The RAM is sampled
  // before the same-edge write lands, giving read-before-write collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_stage0_q <= '0;
      rd_data_q   <= '0;
    end else if (rd_ce) begin
      rd_stage0_q <= rd_in_range ? mem[rd_idx] : '0;
      rd_data_q   <= rd_stage0_q;
    end
  end

  assign done    = done_q;
  assign count   = count_q;
  assign rd_data = rd_data_q;

endmodule : fc2_bias_sink

// File: tb/tb_fc2_bias_sink.sv
// ---------------------------------------------------------------------------
// tb_fc2_bias_sink
//   Three instances:
//     u0 : defaults (32 x 16-bit words, WRAP=0)
//     u1 : 4 x 8-bit elements per beat, 8 words, WRAP=0
//     u2 : 4 x 16-bit words, WRAP=1
//   Expected values come from plain arrays indexed by beat number.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fc2_bias_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- u0 : defaults ----------------
  fc2_bias_sink_if #(.BIAS_PRECISION_0(16), .BIAS_PARALLELISM_DIM_0(1)) if0 ();
  logic        rst0, clear0, done0, rd_ce0;
  logic [5:0]  count0, rd_addr0;
  logic [15:0] rd_data0;

  fc2_bias_sink u0 (
    .clk     (clk),
    .rst     (rst0),
    .in_if   (if0.slave),
    .clear   (clear0),
    .done    (done0),
    .count   (count0),
    .rd_addr (rd_addr0),
    .rd_ce   (rd_ce0),
    .rd_data (rd_data0)
  );

  // ---------------- u1 : 4 x 8-bit, depth 8 ----------------
  fc2_bias_sink_if #(.BIAS_PRECISION_0(8), .BIAS_PARALLELISM_DIM_0(4)) if1 ();
  logic        rst1, clear1, done1, rd_ce1;
  logic [3:0]  count1, rd_addr1;
  logic [31:0] rd_data1;

  fc2_bias_sink #(
    .BIAS_TENSOR_SIZE_DIM_0 (32),
    .BIAS_PRECISION_0       (8),
    .BIAS_PARALLELISM_DIM_0 (4)
  ) u1 (
    .clk     (clk),
    .rst     (rst1),
    .in_if   (if1.slave),
    .clear   (clear1),
    .done    (done1),
    .count   (count1),
    .rd_addr (rd_addr1),
    .rd_ce   (rd_ce1),
    .rd_data (rd_data1)
  );

  // ---------------- u2 : WRAP=1, depth 4 ----------------
  fc2_bias_sink_if #(.BIAS_PRECISION_0(16), .BIAS_PARALLELISM_DIM_0(1)) if2 ();
  logic        rst2, clear2, done2, rd_ce2;
  logic [2:0]  count2, rd_addr2;
  logic [15:0] rd_data2;

  fc2_bias_sink #(
    .BIAS_TENSOR_SIZE_DIM_0 (4),
    .WRAP                   (1)
  ) u2 (
    .clk     (clk),
    .rst     (rst2),
    .in_if   (if2.slave),
    .clear   (clear2),
    .done    (done2),
    .count   (count2),
    .rd_addr (rd_addr2),
    .rd_ce   (rd_ce2),
    .rd_data (rd_data2)
  );

  // Reference memories: what each address should hold after the writes so far.
  logic [15:0] m0 [32];
  logic [15:0] m2 [4];
  int          cnt0, cnt1;

  // Read one word: present the address, two enabled cycles, then sample.
  task automatic read0(input int a, output logic [15:0] d);
    rd_addr0 = 6'(a); rd_ce0 = 1'b1;
    tick(); tick();
    rd_ce0 = 1'b0;
    d = rd_data0;
  endtask

  task automatic read1(input int a, output logic [31:0] d);
    rd_addr1 = 4'(a); rd_ce1 = 1'b1;
    tick(); tick();
    rd_ce1 = 1'b0;
    d = rd_data1;
  endtask

  task automatic read2(input int a, output logic [15:0] d);
    rd_addr2 = 3'(a); rd_ce2 = 1'b1;
    tick(); tick();
    rd_ce2 = 1'b0;
    d = rd_data2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d16;
    logic [31:0] d32;
    logic [31:0] exp32;
    logic        exp_acc;

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    clear0 = 1'b0; clear1 = 1'b0; clear2 = 1'b0;
    rd_ce0 = 1'b0; rd_ce1 = 1'b0; rd_ce2 = 1'b0;
    rd_addr0 = '0; rd_addr1 = '0; rd_addr2 = '0;
    if0.data_in_valid = 1'b0; if0.data_in[0] = '0;
    if1.data_in_valid = 1'b0;
    for (int j = 0; j < 4; j++) if1.data_in[j] = '0;
    if2.data_in_valid = 1'b0; if2.data_in[0] = '0;
    tick(); tick();

    // ---- reset state ----
    check("rst_ready0", 64'(if0.data_in_ready), 64'd0);
    check("rst_done0",  64'(done0),   64'd0);
    check("rst_count0", 64'(count0),  64'd0);
    check("rst_rd0",    64'(rd_data0), 64'd0);
    check("rst_count1", 64'(count1),  64'd0);
    check("rst_rd1",    64'(rd_data1), 64'd0);
    check("rst_done2",  64'(done2),   64'd0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    check("rst_release_ready0", 64'(if0.data_in_ready), 64'd1);

    // ---- A: fill u0 with valid held high, then beat 0xBEEF must stall ----
    cnt0 = 0;
    if0.data_in_valid = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if0.data_in[0] = (cnt0 < 32) ? 16'(16'h1000 + cnt0) : 16'hBEEF;
      #1;
      exp_acc = (cnt0 < 32);
      check("a_ready", 64'(if0.data_in_ready), 64'(exp_acc));
      tick();
      if (exp_acc) begin
        m0[cnt0] = 16'(16'h1000 + cnt0);
        cnt0++;
      end
      check("a_count", 64'(count0), 64'(cnt0));
      check("a_done",  64'(done0),  64'(cnt0 == 32));
    end
    if0.data_in_valid = 1'b0;

    // ---- B: pipelined readback, one address per cycle ----
    rd_ce0 = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      rd_addr0 = (k < 32) ? 6'(k) : 6'd0;
      tick();
      if (k >= 1) check("b_readback", 64'(rd_data0), 64'(m0[k-1]));
    end
    // rd_ce low freezes both stages: output holds word 31, stage0 holds word 0.
    rd_ce0 = 1'b0; rd_addr0 = 6'd5;
    tick(); tick();
    check("b_freeze_out", 64'(rd_data0), 64'(m0[31]));
    rd_ce0 = 1'b1;
    tick();
    check("b_freeze_stage0", 64'(rd_data0), 64'(m0[0]));
    rd_ce0 = 1'b0;

    // ---- C: clear in FULL with a beat presented ----
    clear0 = 1'b1; if0.data_in_valid = 1'b1; if0.data_in[0] = 16'hAAAA;
    #1;
    check("c_ready_during_clear", 64'(if0.data_in_ready), 64'd0);
    tick();
    clear0 = 1'b0;
    #1;
    cnt0 = 0;
    check("c_ready_after", 64'(if0.data_in_ready), 64'd1);
    check("c_done_after",  64'(done0),  64'd0);
    check("c_count_after", 64'(count0), 64'd0);
    tick();
    m0[0] = 16'hAAAA; cnt0 = 1;
    if0.data_in_valid = 1'b0;
    check("c_count_one", 64'(count0), 64'(cnt0));
    read0(0, d16); check("c_addr0", 64'(d16), 64'(m0[0]));
    read0(1, d16); check("c_addr1", 64'(d16), 64'(m0[1]));

    // ---- D: read/write collision at address 3 ----
    if0.data_in_valid = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      if0.data_in[0] = 16'(16'h2000 + i);
      tick();
      m0[cnt0] = 16'(16'h2000 + i);
      cnt0++;
    end
    if0.data_in[0] = 16'h5555;
    rd_addr0 = 6'd3; rd_ce0 = 1'b1;
    tick();
    if0.data_in_valid = 1'b0;
    tick();
    check("d_collision_old", 64'(rd_data0), 64'(m0[3]));
    m0[3] = 16'h5555; cnt0++;
    tick();
    check("d_collision_new", 64'(rd_data0), 64'(m0[3]));
    rd_ce0 = 1'b0;
    check("d_count", 64'(count0), 64'(cnt0));

    // ---- E: rst mid-tensor, then a fresh random-valid stream ----
    clear0 = 1'b1; tick(); clear0 = 1'b0;
    cnt0 = 0;
    if0.data_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if0.data_in[0] = 16'($urandom);
      tick();
      m0[cnt0] = if0.data_in[0];
      cnt0++;
    end
    check("e_count10", 64'(count0), 64'(cnt0));
    rst0 = 1'b1;
    #1;
    check("e_ready_in_rst", 64'(if0.data_in_ready), 64'd0);
    tick();
    cnt0 = 0;
    check("e_count_rst", 64'(count0),   64'd0);
    check("e_done_rst",  64'(done0),    64'd0);
    check("e_rd_rst",    64'(rd_data0), 64'd0);
    rst0 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (cnt0 == 32) break;
      if0.data_in_valid = 1'($urandom_range(0, 1));
      if0.data_in[0]    = 16'($urandom);
      #1;
      exp_acc = if0.data_in_valid;
      tick();
      if (exp_acc) begin
        m0[cnt0] = if0.data_in[0];
        cnt0++;
      end
      check("e_count_track", 64'(count0), 64'(cnt0));
    end
    if0.data_in_valid = 1'b0;
    check("e_done",  64'(done0),  64'd1);
    check("e_count", 64'(count0), 64'd32);
    for (int a = 0; a < 32; a++) begin
      read0(a, d16);
      check("e_readback", 64'(d16), 64'(m0[a]));
    end

    // ---- F: u1, four 8-bit elements per beat, random valid ----
    cnt1 = 0;
    for (int c = 0; c < 200; c++) begin
      if (cnt1 == 8) break;
      if1.data_in_valid = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++) if1.data_in[j] = 8'(4 * cnt1 + j);
      #1;
      check("f_ready", 64'(if1.data_in_ready), 64'd1);
      exp_acc = if1.data_in_valid;
      tick();
      if (exp_acc) cnt1++;
      check("f_count_track", 64'(count1), 64'(cnt1));
    end
    if1.data_in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("f_ready_full", 64'(if1.data_in_ready), 64'd0);
      tick();
      check("f_count_hold", 64'(count1), 64'd8);
    end
    if1.data_in_valid = 1'b0;
    check("f_done", 64'(done1), 64'd1);
    for (int k = 0; k < 8; k++) begin
      exp32 = '0;
      for (int j = 0; j < 4; j++) exp32 = exp32 | (32'(4 * k + j) << (8 * j));
      read1(k, d32);
      check("f_readback", 64'(d32), 64'(exp32));
    end

    // ---- G: u2, WRAP=1 with 6 beats into 4 words ----
    if2.data_in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if2.data_in[0] = 16'(i);
      #1;
      check("g_ready", 64'(if2.data_in_ready), 64'd1);
      tick();
      m2[(i - 1) % 4] = 16'(i);
      check("g_count", 64'(count2), 64'((i < 4) ? i : 4));
      check("g_done",  64'(done2),  64'(i >= 4));
    end
    if2.data_in_valid = 1'b0;
    #1;
    check("g_ready_after", 64'(if2.data_in_ready), 64'd1);
    for (int a = 0; a < 4; a++) begin
      read2(a, d16);
      check("g_readback", 64'(d16), 64'(m2[a]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_fc2_bias_sink
